// File: rtl/bitty_ctrl_seq.sv
// Bitty control sequencer: a four-state FSM (IDLE, S_LOAD, C_LOAD, WRITE) that turns one
// captured instruction into bus, latch and register-write strobes. Optional stall gate: CTRL_STALL_EN.
module bitty_ctrl_seq #(
  parameter int  NREGS  = 8,
  parameter int  ALU_W  = 3,
  parameter int  INST_W = 16,
  localparam int RSW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic              stall,
  output logic [ALU_W-1:0]  alu_sel,
  output logic [RSW:0]      mux_sel,
  output logic [NREGS-1:0]  reg_enable,
  output logic              s_enable,
  output logic              c_enable,
  output logic              done,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {IDLE, S_LOAD, C_LOAD, WRITE} state_t;

  state_t            state_q, state_d;
  logic [INST_W-1:0] inst_q;
  logic [15:0]       retired_q;
  logic              hold;
  logic              accept;

  logic [RSW-1:0]    rx, ry;
  logic [ALU_W-1:0]  alu;
  logic [1:0]        mode;

`ifdef CTRL_STALL_EN
  assign hold = stall;
`else
  logic stall_unused;
  assign hold         = 1'b0;
  assign stall_unused = stall;
`endif

  // Fields come from the captured copy so the source may change right after acceptance.
  assign rx   = inst_q[INST_W-1 -: RSW];
  assign ry   = inst_q[INST_W-RSW-1 -: RSW];
  assign alu  = inst_q[ALU_W+1:2];
  assign mode = inst_q[1:0];

  logic inst_unused;
  assign inst_unused = ^inst_q;

  // Gated by reset directly so no accept is advertised while reset is held.
  assign inst_ready = reset && !hold && (state_q == IDLE || state_q == WRITE);
  assign accept     = inst_valid && inst_ready;
  assign retired    = retired_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        inst_q <= inst;
      if (done)
        retired_q <= retired_q + 16'd1;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    alu_sel    = '0;
    mux_sel    = '0;
    reg_enable = '0;
    s_enable   = 1'b0;
    c_enable   = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        alu_sel  = alu;
        mux_sel  = {1'b0, rx};
        s_enable = !hold;
        state_d  = C_LOAD;
      end
      C_LOAD: begin
        alu_sel  = alu;
        mux_sel  = {(mode == 2'b01), ry};
        c_enable = !hold;
        state_d  = WRITE;
      end
      WRITE: begin
        alu_sel = alu;
        mux_sel = {1'b0, rx};
        done    = !hold;
        // Modes 10/11 are NOPs: they retire but never write the register file.
        if (!hold && !mode[1])
          reg_enable = NREGS'(1) << rx;
        state_d = accept ? S_LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hold)
      state_d = state_q;
  end

endmodule

// File: tb/tb_bitty_ctrl_seq.sv
// Self-checking bench for bitty_ctrl_seq: directed vector table, multi-cycle corner cases
// (back-to-back, mid-op reset, stall, counter wrap) and a randomized run against a queue model.
module tb_bitty_ctrl_seq;

  localparam int NREGS  = 8;
  localparam int ALU_W  = 3;
  localparam int INST_W = 16;
  localparam int RSW    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ready;
  logic              stall;
  logic [ALU_W-1:0]  alu_sel;
  logic [RSW:0]      mux_sel;
  logic [NREGS-1:0]  reg_enable;
  logic              s_enable, c_enable, done;
  logic [15:0]       retired;

  bitty_ctrl_seq #(.NREGS(NREGS), .ALU_W(ALU_W), .INST_W(INST_W)) dut (
    .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .stall(stall), .alu_sel(alu_sel), .mux_sel(mux_sel), .reg_enable(reg_enable),
    .s_enable(s_enable), .c_enable(c_enable), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_retired = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] mk(input int rx, input int ry, input int alu, input int mode);
    logic [15:0] w;
    w        = 16'($urandom);
    w[15:13] = 3'(rx);
    w[12:10] = 3'(ry);
    w[4:2]   = 3'(alu);
    w[1:0]   = 2'(mode);
    return w;
  endfunction

  // Expected outputs for one cycle: phase 0 idle, 1 source load, 2 result load, 3 write.
  typedef struct {
    logic       ready;
    logic [2:0] alu;
    logic [3:0] mux;
    logic [7:0] regen;
    logic       s_en, c_en, dn;
    bit         c_care;
  } outs_t;

  function automatic outs_t model(input int phase, input logic [15:0] w);
    outs_t o;
    int rx, ry, mode;
    rx = int'(w[15:13]); ry = int'(w[12:10]); mode = int'(w[1:0]);
    o = '{ready: (phase == 0 || phase == 3), alu: (phase == 0) ? 3'd0 : w[4:2],
          mux: 4'd0, regen: 8'd0, s_en: (phase == 1), c_en: (phase == 2), dn: (phase == 3),
          c_care: 1'b1};
    if (phase == 1 || phase == 3) o.mux = 4'(rx);
    if (phase == 2) begin
      o.mux    = (mode == 1) ? 4'(8 + ry) : 4'(ry);
      o.c_care = (mode < 2);
    end
    if (phase == 3 && mode < 2) o.regen = 8'(1 << rx);
    return o;
  endfunction

  task automatic check_outs(input string tag, input outs_t e);
    check({tag, ".inst_ready"}, 32'(inst_ready), 32'(e.ready));
    check({tag, ".alu_sel"},    32'(alu_sel),    32'(e.alu));
    check({tag, ".reg_enable"}, 32'(reg_enable), 32'(e.regen));
    check({tag, ".s_enable"},   32'(s_enable),   32'(e.s_en));
    check({tag, ".done"},       32'(done),       32'(e.dn));
    if (e.c_care) begin
      check({tag, ".mux_sel"},  32'(mux_sel),  32'(e.mux));
      check({tag, ".c_enable"}, 32'(c_enable), 32'(e.c_en));
    end
  endtask

  // One directed instruction from IDLE: the table supplies the literal expectations.
  typedef struct {
    int         rx, ry, alu, mode;
    logic [3:0] c_mux;
    logic [7:0] w_regen;
    bit         c_care;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    inst = mk(v.rx, v.ry, v.alu, v.mode); inst_valid = 1'b1;
    check({tag, ".idle_ready"}, 32'(inst_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0; inst = 16'($urandom);
    check({tag, ".s_enable"}, 32'(s_enable), 32'd1);
    check({tag, ".s_mux"},    32'(mux_sel),  32'(v.rx));
    check({tag, ".s_alu"},    32'(alu_sel),  32'(v.alu));
    check({tag, ".s_ready"},  32'(inst_ready), 32'd0);
    @(negedge clk);
    check({tag, ".c_ready"},  32'(inst_ready), 32'd0);
    if (v.c_care) begin
      check({tag, ".c_enable"}, 32'(c_enable), 32'd1);
      check({tag, ".c_mux"},    32'(mux_sel),  32'(v.c_mux));
    end
    @(negedge clk);
    check({tag, ".w_done"},  32'(done),       32'd1);
    check({tag, ".w_regen"}, 32'(reg_enable), 32'(v.w_regen));
    check({tag, ".w_mux"},   32'(mux_sel),    32'(v.rx));
    exp_retired = exp_retired + 16'd1;
    @(posedge clk); #1;
    check({tag, ".retired"}, 32'(retired), 32'(exp_retired));
  endtask

  typedef struct packed { int phase; logic [15:0] w; } slot_t;

  initial begin
    vec_t  vecs[5];
    outs_t idle_o;
    slot_t q[$];
    slot_t cur;
    logic [15:0] b2b[3];
    int    done_mask, ready_mask, done_cycle;

    vecs[0] = '{rx: 3, ry: 5, alu: 2, mode: 0, c_mux: 4'd5,     w_regen: 8'h08, c_care: 1};
    vecs[1] = '{rx: 2, ry: 6, alu: 1, mode: 1, c_mux: 4'b1110,  w_regen: 8'h04, c_care: 1};
    vecs[2] = '{rx: 7, ry: 0, alu: 7, mode: 3, c_mux: 4'd0,     w_regen: 8'h00, c_care: 0};
    vecs[3] = '{rx: 0, ry: 7, alu: 5, mode: 0, c_mux: 4'd7,     w_regen: 8'h01, c_care: 1};
    vecs[4] = '{rx: 5, ry: 1, alu: 3, mode: 2, c_mux: 4'd0,     w_regen: 8'h00, c_care: 0};
    idle_o  = '{ready: 1'b0, alu: 3'd0, mux: 4'd0, regen: 8'd0, s_en: 1'b0, c_en: 1'b0,
                dn: 1'b0, c_care: 1'b1};

    reset = 1'b0; inst = '0; inst_valid = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b1;
    check_outs("in_reset", idle_o);
    check("in_reset.retired", 32'(retired), 32'd0);
    inst_valid = 1'b0;
    reset = 1'b1;
    #1;
    idle_o.ready = 1'b1;
    check_outs("after_reset", idle_o);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: valid stays high across three instructions.
    for (int i = 0; i < 3; i++) b2b[i] = mk(i + 1, 7 - i, i, 0);
    @(negedge clk);
    inst = b2b[0]; inst_valid = 1'b1;
    @(posedge clk);
    done_mask = 0; ready_mask = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done)       done_mask  |= (1 << k);
      if (inst_ready) ready_mask |= (1 << k);
      if (k == 6) check("b2b.regen2", 32'(reg_enable), 32'(8'(1 << 2)));
      if (k == 3) inst = b2b[1];
      if (k == 6) inst = b2b[2];
      if (k == 9) inst_valid = 1'b0;
    end
    check("b2b.done_cycles",  32'(done_mask),  32'((1 << 3) | (1 << 6) | (1 << 9)));
    check("b2b.ready_cycles", 32'(ready_mask), 32'((1 << 3) | (1 << 6) | (1 << 9) | (1 << 10)));
    exp_retired = exp_retired + 16'd3;
    check("b2b.retired", 32'(retired), 32'(exp_retired));

    // Reset asserted during C_LOAD abandons the instruction.
    @(negedge clk);
    inst = mk(4, 2, 6, 0); inst_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); inst_valid = 1'b0;
    @(negedge clk);
    check("rst.c_enable_before", 32'(c_enable), 32'd1);
    #1 reset = 1'b0;
    #1;
    idle_o.ready = 1'b0;
    check_outs("rst.during", idle_o);
    check("rst.retired", 32'(retired), 32'd0);
    @(negedge clk);
    check("rst.no_done",  32'(done),       32'd0);
    check("rst.no_regen", 32'(reg_enable), 32'd0);
    reset = 1'b1;
    exp_retired = 16'd0;
    #1;
    check("rst.ready_after", 32'(inst_ready), 32'd1);
    @(posedge clk); #1;
    idle_o.ready = 1'b1;
    check_outs("rst.resume_idle", idle_o);

    // Stall for two cycles while in C_LOAD.
    @(negedge clk);
    inst = mk(6, 3, 4, 0); inst_valid = 1'b1;
    @(posedge clk);
    done_cycle = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      inst_valid = 1'b0;
      stall = (k == 2 || k == 3);
      #1;
`ifdef CTRL_STALL_EN
      if (k == 2) check("stall.c_enable", 32'(c_enable), 32'd0);
`else
      if (k == 2) check("stall.c_enable", 32'(c_enable), 32'd1);
`endif
      if (done && done_cycle == 0) done_cycle = k;
    end
    stall = 1'b0;
`ifdef CTRL_STALL_EN
    check("stall.done_cycle", 32'(done_cycle), 32'd5);
`else
    check("stall.done_cycle", 32'(done_cycle), 32'd3);
`endif
    exp_retired = exp_retired + 16'd1;
    check("stall.retired", 32'(retired), 32'(exp_retired));

    // Counter wrap: preload the count to 0xFFFF, then one NOP retires.
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    #1;
    exp_retired = 16'hFFFF;
    check("wrap.preset", 32'(retired), 32'(exp_retired));
    run_vec(vecs[2], "wrap");
    check("wrap.zero", 32'(retired), 32'd0);

    // Randomized traffic against the queue model: each accept schedules three output cycles.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      cur = (q.size() > 0) ? q[0] : '{phase: 0, w: 16'd0};
      check_outs($sformatf("rand%0d", c), model(cur.phase, cur.w));
      check($sformatf("rand%0d.retired", c), 32'(retired), 32'(exp_retired));
      inst_valid = ($urandom_range(3) != 0);
      inst       = 16'($urandom);
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (cur.phase == 3) exp_retired = exp_retired + 16'd1;
      end
      if (inst_valid && q.size() == 0) begin
        q.push_back('{phase: 1, w: inst});
        q.push_back('{phase: 2, w: inst});
        q.push_back('{phase: 3, w: inst});
      end
    end
    inst_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
